// File: rtl/brick_field.sv
// Breakout brick field: draws a grid of bricks, detects ball/brick overlap and
// removes at most one brick per frame, keeping a saturating 3-digit BCD score.
module brick_field #(
    parameter int FIELD_X    = 64,
    parameter int FIELD_Y    = 48,
    parameter int BRICK_COLS = 8,
    parameter int BRICK_ROWS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  hpos,
    input  logic [8:0]  vpos,
    input  logic        ball_pixel,
    input  logic        frame_pulse,
    input  logic        game_active,
    input  logic        reset_field,
    output logic        brick_pixel,
    output logic        block_collision,
    output logic [11:0] score,
    output logic [5:0]  bricks_remaining,
    output logic        field_cleared
);

    localparam int NB = BRICK_COLS * BRICK_ROWS;
    localparam int IW = $clog2(NB);
    localparam int CW = $clog2(BRICK_COLS);
    localparam int RW = $clog2(BRICK_ROWS);
    localparam int FW = BRICK_COLS * 64;
    localparam int FH = BRICK_ROWS * 16;

    logic [NB-1:0] r_alive;
    logic [11:0]   r_score;
    logic [5:0]    r_remaining;
    logic          r_brick_pixel;
    logic          r_ball_d;
    logic [IW-1:0] r_pix_idx;
    logic [RW-1:0] r_pix_row;
    logic          r_hit_pending;
    logic [IW-1:0] r_hit_idx;
    logic [RW-1:0] r_hit_row;
    logic          r_field_cleared;

    // Offsets are one bit wider than the position so a pixel left of/above the
    // field wraps to a large value and fails the single upper-bound compare.
    logic [10:0]   w_dx;
    logic [9:0]    w_dy;
    logic          w_in_field;
    logic          w_gap;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic [IW-1:0] w_idx;
    logic          w_collision;
    logic [3:0]    w_add;
    logic [11:0]   w_score_sum;
    logic [NB-1:0] w_hit_onehot;

    assign w_dx       = {1'b0, hpos} - 11'(FIELD_X);
    assign w_dy       = {1'b0, vpos} - 10'(FIELD_Y);
    assign w_in_field = (w_dx < 11'(FW)) && (w_dy < 10'(FH));
    assign w_gap      = (w_dx[5:0] == 6'd0) || (w_dy[3:0] == 4'd0);
    assign w_col      = w_dx[6 +: CW];
    assign w_row      = w_dy[4 +: RW];
    assign w_idx      = IW'(w_row) * IW'(BRICK_COLS) + IW'(w_col);

    assign w_collision = r_brick_pixel & r_ball_d;

    // Bricks in the top row are worth the most points.
    assign w_add       = 4'(BRICK_ROWS) - 4'(r_hit_row);
    assign w_score_sum = bcd_add(r_score, w_add);

    for (genvar gi = 0; gi < NB; gi++) begin : g_hit_onehot
        assign w_hit_onehot[gi] = (r_hit_idx == IW'(gi));
    end

    function automatic logic [11:0] bcd_add(input logic [11:0] s, input logic [3:0] a);
        logic [4:0]  d0;
        logic [4:0]  d1;
        logic [4:0]  d2;
        logic        c0;
        logic        c1;
        logic [11:0] res;
        d0 = {1'b0, s[3:0]} + {1'b0, a};
        c0 = (d0 > 5'd9);
        if (c0) d0 = d0 - 5'd10;
        d1 = {1'b0, s[7:4]} + {4'd0, c0};
        c1 = (d1 > 5'd9);
        if (c1) d1 = d1 - 5'd10;
        d2 = {1'b0, s[11:8]} + {4'd0, c1};
        if (d2 > 5'd9) res = 12'h999;
        else           res = {d2[3:0], d1[3:0], d0[3:0]};
        return res;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_alive         <= '1;
            r_score         <= 12'h000;
            r_remaining     <= 6'(NB);
            r_brick_pixel   <= 1'b0;
            r_ball_d        <= 1'b0;
            r_pix_idx       <= '0;
            r_pix_row       <= '0;
            r_hit_pending   <= 1'b0;
            r_hit_idx       <= '0;
            r_hit_row       <= '0;
            r_field_cleared <= 1'b0;
        end else begin
            r_brick_pixel   <= w_in_field && !w_gap && r_alive[w_idx];
            r_pix_idx       <= w_idx;
            r_pix_row       <= w_row;
            r_ball_d        <= ball_pixel;
            r_field_cleared <= 1'b0;

            if (frame_pulse) begin
                r_hit_pending <= 1'b0;
                if (reset_field) begin
                    r_alive     <= '1;
                    r_score     <= 12'h000;
                    r_remaining <= 6'(NB);
                end else if (r_remaining == 6'd0) begin
                    r_alive     <= '1;
                    r_remaining <= 6'(NB);
                end else if (r_hit_pending && r_alive[r_hit_idx]) begin
                    // The alive check keeps a stale hit on a dead brick harmless.
                    r_alive     <= r_alive & ~w_hit_onehot;
                    r_remaining <= r_remaining - 6'd1;
                    r_score     <= w_score_sum;
                    if (r_remaining == 6'd1) r_field_cleared <= 1'b1;
                end
            end else if (w_collision && game_active && !r_hit_pending) begin
                r_hit_pending <= 1'b1;
                r_hit_idx     <= r_pix_idx;
                r_hit_row     <= r_pix_row;
            end
        end
    end

    assign brick_pixel      = r_brick_pixel;
    assign block_collision  = w_collision;
    assign score            = r_score;
    assign bricks_remaining = r_remaining;
    assign field_cleared    = r_field_cleared;

endmodule

// File: tb/tb_brick_field.sv
// Self-checking bench for brick_field: directed scenarios plus random pixels,
// compared every cycle against a simple brick-array model of the game field.
module tb_brick_field;

    logic        clk;
    logic        rst;
    logic [9:0]  hpos;
    logic [8:0]  vpos;
    logic        ball_pixel;
    logic        frame_pulse;
    logic        game_active;
    logic        reset_field;
    logic        brick_pixel;
    logic        block_collision;
    logic [11:0] score;
    logic [5:0]  bricks_remaining;
    logic        field_cleared;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model of the field
    bit m_alive [32];
    int m_score;
    int m_rem;
    bit m_pend;
    int m_hidx;
    bit m_breg;
    bit m_ballreg;
    int m_pidx;
    bit m_fc;

    brick_field dut (
        .clk              (clk),
        .rst              (rst),
        .hpos             (hpos),
        .vpos             (vpos),
        .ball_pixel       (ball_pixel),
        .frame_pulse      (frame_pulse),
        .game_active      (game_active),
        .reset_field      (reset_field),
        .brick_pixel      (brick_pixel),
        .block_collision  (block_collision),
        .score            (score),
        .bricks_remaining (bricks_remaining),
        .field_cleared    (field_cleared)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int s);
        return 12'((s / 100) * 256 + ((s / 10) % 10) * 16 + (s % 10));
    endfunction

    function automatic bit pix_on(input int h, input int v, output int idx);
        int dx;
        int dy;
        dx  = h - 64;
        dy  = v - 48;
        idx = 0;
        if (dx < 0 || dx >= 512 || dy < 0 || dy >= 64) return 1'b0;
        idx = (dy / 16) * 8 + dx / 64;
        if (dx % 64 == 0 || dy % 16 == 0) return 1'b0;
        return m_alive[idx];
    endfunction

    task automatic refill();
        for (int i = 0; i < 32; i++) m_alive[i] = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check every output.
    task automatic cyc(input int h, input int v, input bit b, input bit ga,
                       input bit fp, input bit rf, input bit r);
        int  idx;
        bit  on;
        bit  coll;
        int  add;
        @(negedge clk);
        hpos        = 10'(h);
        vpos        = 9'(v);
        ball_pixel  = b;
        game_active = ga;
        frame_pulse = fp;
        reset_field = rf;
        rst         = r;

        on   = pix_on(h, v, idx);
        coll = m_breg && m_ballreg;
        if (r) begin
            refill();
            m_score = 0; m_rem = 32; m_pend = 0;
            m_breg = 0; m_ballreg = 0; m_fc = 0;
        end else begin
            m_fc = 0;
            if (fp) begin
                if (rf) begin
                    refill(); m_score = 0; m_rem = 32;
                end else if (m_rem == 0) begin
                    refill(); m_rem = 32;
                end else if (m_pend && m_alive[m_hidx]) begin
                    m_alive[m_hidx] = 1'b0;
                    m_rem--;
                    add = 4 - m_hidx / 8;
                    m_score = (m_score + add > 999) ? 999 : m_score + add;
                    if (m_rem == 0) m_fc = 1;
                end
                m_pend = 0;
            end else if (coll && ga && !m_pend) begin
                m_pend = 1;
                m_hidx = m_pidx;
            end
            m_breg    = on;
            m_pidx    = idx;
            m_ballreg = b;
        end

        @(posedge clk);
        #1;
        chk("brick_pixel", 12'(brick_pixel), 12'(m_breg));
        chk("block_collision", 12'(block_collision), 12'(m_breg && m_ballreg));
        chk("score", score, to_bcd(m_score));
        chk("bricks_remaining", 12'(bricks_remaining), 12'(m_rem));
        chk("field_cleared", 12'(field_cleared), 12'(m_fc));
        if (fp && !r)
            $display("frame: reset_field=%0d score=%h remaining=%0d cleared=%0d",
                     rf, score, bricks_remaining, field_cleared);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic hit(input int col, input int row);
        cyc(64 + col * 64 + 32, 48 + row * 16 + 8, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic frame(input bit rf);
        cyc(0, 0, 0, 1, 1, rf, 0);
    endtask

    initial begin
        int first;
        rst = 1'b1; hpos = '0; vpos = '0; ball_pixel = 1'b0;
        frame_pulse = 1'b0; game_active = 1'b0; reset_field = 1'b0;
        refill();
        m_score = 0; m_rem = 32; m_pend = 0; m_hidx = 0;
        m_breg = 0; m_ballreg = 0; m_pidx = 0; m_fc = 0;

        // Reset state, first brick pixel, gap and out-of-field pixels
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(65, 49, 0, 0, 0, 0, 0);
        cyc(128, 50, 0, 0, 0, 0, 0);
        cyc(600, 50, 1, 1, 0, 0, 0);
        cyc(70, 50, 0, 0, 0, 0, 0);

        // Single hit on brick 0, then revisit it
        hit(0, 0);
        frame(0);
        cyc(70, 50, 0, 1, 0, 0, 0);

        // Two hits in one frame: only the first counts
        cyc(0, 0, 0, 0, 0, 0, 1);
        hit(0, 0);
        hit(1, 1);
        frame(0);
        cyc(133, 69, 0, 1, 0, 0, 0);
        cyc(70, 50, 0, 1, 0, 0, 0);

        // Ball parked on a brick across the frame edge: re-hit of dead brick
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(200, 70, 1, 1, 0, 0, 0);
        cyc(200, 70, 1, 1, 0, 0, 0);
        cyc(200, 70, 1, 1, 1, 0, 0);
        cyc(200, 70, 1, 1, 0, 0, 0);
        idle(2);
        frame(0);

        // Clear the whole field, then refill on the following frame
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 32; i++) begin
            hit(i % 8, i / 8);
            frame(0);
            idle(1);
        end
        frame(0);
        cyc(65, 49, 0, 1, 0, 0, 0);

        // Pending hit discarded by reset_field
        hit(2, 3);
        frame(1);
        idle(1);
        frame(0);

        // Reset overrides a frame pulse with a hit pending
        hit(3, 2);
        cyc(0, 0, 0, 1, 1, 0, 1);
        frame(0);

        // Saturation at 999
        for (int k = 0; k < 900 && m_score < 999; k++) begin
            if (m_rem == 0) begin
                frame(0);
            end else begin
                first = 0;
                while (!m_alive[first]) first++;
                hit(first % 8, first / 8);
                frame(0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (m_rem == 0) frame(0);
            hit(0, 0);
            frame(0);
            hit(7, 0);
            frame(0);
        end

        // Randomized pixels, balls and frame strobes
        cyc(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            int  h;
            int  v;
            bit  b;
            bit  ga;
            bit  fp;
            bit  rf;
            bit  r;
            h  = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(40, 600));
            v  = (($urandom_range(0, 3) == 0) ? $urandom_range(0, 511) : $urandom_range(30, 130));
            b  = ($urandom_range(0, 1) == 1);
            ga = ($urandom_range(0, 4) != 0);
            fp = ($urandom_range(0, 15) == 0);
            rf = fp && ($urandom_range(0, 19) == 0);
            r  = ($urandom_range(0, 999) == 0);
            cyc(h, v, b, ga, fp, rf, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
